// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid pipeline register (in_*/out_* valid-ready, flush, stall/bubble counters, active-low sync reset)
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] main_q, skid_q, main_n, skid_n;
  logic in_fire, out_fire;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    state_n  = flush ? EMPTY :
               state == EMPTY ? (in_fire ? BUSY : EMPTY) :
               state == BUSY  ? (in_fire & !out_fire ? FULL : !in_fire & out_fire ? EMPTY : BUSY) :
               (out_fire ? BUSY : FULL);
    main_n   = flush ? NOP_VALUE :
               state == EMPTY ? (in_fire ? in_data : main_q) :
               state == BUSY  ? (in_fire & out_fire ? in_data : out_fire ? NOP_VALUE : main_q) :
               (out_fire ? skid_q : main_q);
    skid_n   = flush ? NOP_VALUE :
               state == BUSY && in_fire && !out_fire ? in_data :
               state == FULL && out_fire ? NOP_VALUE : skid_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && out_ready && bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed vectors, counter/reset sequences and a queue-model random run for pipe_skid_stage
module tb_pipe_skid_stage;
  logic clk = 0, reset = 0, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0, cnt_clr = 0;
  logic [31:0] in_data = 0, out_data;
  logic [3:0] stall_cnt, bubble_cnt;
  int checks = 0, errors = 0;
  pipe_skid_stage #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst_n, iv, ordy, fl;
    logic [31:0] d;
    logic ov, ir;
    logic [31:0] od;
  } vec_t;
  vec_t v[$];
  logic [31:0] q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic iv, input logic [31:0] d, input logic ordy, input logic fl, input logic cc);
    reset = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl; cnt_clr = cc;
  endtask
  task automatic chk_out(input string name, input logic ov, input logic ir, input logic [31:0] od);
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    chk({name, ".out_data"}, out_data, od);
  endtask
  task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                     input logic ov, input logic ir, input logic [31:0] od);
    vec_t e;
    e.rst_n = r; e.iv = iv; e.d = d; e.ordy = ordy; e.fl = fl; e.ov = ov; e.ir = ir; e.od = od;
    v.push_back(e);
  endtask
  initial begin
    add(1, 1, 32'h11, 1, 0, 1, 1, 32'h11);
    add(1, 1, 32'h22, 1, 0, 1, 1, 32'h22);
    add(1, 1, 32'h33, 1, 0, 1, 1, 32'h33);
    add(1, 0, 32'h0,  1, 0, 0, 1, 32'h0);
    add(1, 1, 32'hA,  0, 0, 1, 1, 32'hA);
    add(1, 1, 32'hB,  0, 0, 1, 0, 32'hA);
    add(1, 1, 32'hC,  0, 0, 1, 0, 32'hA);
    add(1, 0, 32'h0,  1, 0, 1, 1, 32'hB);
    add(1, 0, 32'h0,  1, 0, 0, 1, 32'h0);
    add(1, 1, 32'hA,  0, 0, 1, 1, 32'hA);
    add(1, 1, 32'hB,  0, 0, 1, 0, 32'hA);
    add(1, 1, 32'hC,  1, 1, 0, 1, 32'h0);
    add(1, 0, 32'h0,  0, 0, 0, 1, 32'h0);
    add(1, 1, 32'hD,  0, 0, 1, 1, 32'hD);
    add(1, 1, 32'hE,  0, 0, 1, 0, 32'hD);
    add(1, 1, 32'hF,  1, 0, 1, 1, 32'hE);
    add(1, 1, 32'hF,  0, 0, 1, 0, 32'hE);
    add(0, 1, 32'h9,  1, 1, 0, 1, 32'h0);
    add(1, 0, 32'h0,  1, 0, 0, 1, 32'h0);
    add(1, 1, 32'h44, 0, 0, 1, 1, 32'h44);
    add(1, 0, 32'h0,  0, 0, 1, 1, 32'h44);
    add(1, 1, 32'h55, 1, 0, 1, 1, 32'h55);
    add(1, 0, 32'h0,  0, 1, 0, 1, 32'h0);
    drive(0, 1, 32'h77, 1, 1, 1);
    step();
    chk_out("in_reset", 0, 1, 32'h0);
    step();
    chk_out("after_reset", 0, 1, 32'h0);
    chk("reset.stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("reset.bubble_cnt", {28'd0, bubble_cnt}, 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk_out("idle_after_reset", 0, 1, 32'h0);
    foreach (v[i]) begin
      drive(v[i].rst_n, v[i].iv, v[i].d, v[i].ordy, v[i].fl, 0);
      step();
      chk_out($sformatf("vec%0d", i), v[i].ov, v[i].ir, v[i].od);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("cnt.reset_stall", {28'd0, stall_cnt}, 32'd0);
    drive(1, 1, 32'h5, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("cnt.stall14", {28'd0, stall_cnt}, 32'd14);
    end
    chk("cnt.stall_sat", {28'd0, stall_cnt}, 32'd15);
    chk("cnt.bubble0", {28'd0, bubble_cnt}, 32'd0);
    cnt_clr = 1;
    step();
    chk("cnt.clr", {28'd0, stall_cnt}, 32'd0);
    cnt_clr = 0;
    step();
    chk("cnt.after_clr", {28'd0, stall_cnt}, 32'd1);
    flush = 1;
    step();
    chk("cnt.flush_keeps", {28'd0, stall_cnt}, 32'd2);
    chk_out("cnt.flush_empty", 0, 1, 32'h0);
    drive(1, 0, 0, 1, 0, 0);
    repeat (3) step();
    chk("cnt.bubble3", {28'd0, bubble_cnt}, 32'd3);
    chk("cnt.stall_hold", {28'd0, stall_cnt}, 32'd2);
    drive(1, 1, 32'hA, 1, 0, 0);
    step();
    drive(1, 1, 32'hB, 0, 0, 0);
    step();
    chk_out("full_before_reset", 1, 0, 32'hA);
    chk("full.stall", {28'd0, stall_cnt}, 32'd3);
    chk("full.bubble", {28'd0, bubble_cnt}, 32'd4);
    drive(0, 0, 0, 1, 0, 0);
    step();
    chk_out("reset_from_full", 0, 1, 32'h0);
    chk("reset_from_full.stall", {28'd0, stall_cnt}, 32'd0);
    chk("reset_from_full.bubble", {28'd0, bubble_cnt}, 32'd0);
    drive(1, 0, 0, 1, 0, 0);
    step();
    chk_out("no_transfer_after_reset", 0, 1, 32'h0);
    q.delete();
    for (int c = 0; c < 20000; c++) begin
      logic iv, ordy, fl, ir_exp;
      logic [31:0] d;
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      fl = $urandom_range(0, 31) == 0;
      d = $urandom;
      drive(1, iv, d, ordy, fl, 0);
      ir_exp = q.size() < 2;
      #1;
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, ir_exp});
      if (q.size() > 0) chk("rnd.out_data", out_data, q[0]);
      out_ready = !ordy;
      #1;
      chk("rnd.in_ready_indep", {31'd0, in_ready}, {31'd0, ir_exp});
      out_ready = ordy;
      if (fl) q.delete();
      else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && ir_exp) q.push_back(d);
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
